mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_lane_align.sv | 31 +++
 rtl/register_bit.sv | 23 ++
 rtl/mem_access_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage memory access controller.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int TIMEOUT_DEFAULT = 16;
  localparam int DWORD_BYTES     = 8;
  localparam int ADDR_W          = 64;
  localparam int DATA_W          = DWORD_BYTES * 8;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: byte enables, store replication, load extraction.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic                   byte_op,
  input  logic [2:0]             offset,
  input  logic [DATA_W-1:0]      wdata_in,
  input  logic [DATA_W-1:0]      rdata_in,
  output logic [DWORD_BYTES-1:0] be,
  output logic [DATA_W-1:0]      wdata_out,
  output logic [DATA_W-1:0]      rdata_out
);

  logic [7:0] lane_byte;

  genvar gi;
  generate
    for (gi = 0; gi < DWORD_BYTES; gi++) begin : g_lane
      // A byte access enables only the addressed lane; a store byte goes to every lane.
      assign be[gi]               = ~byte_op | (offset == 3'(gi));
      assign wdata_out[gi*8 +: 8] = byte_op ? wdata_in[7:0] : wdata_in[gi*8 +: 8];
    end
  endgenerate

  // Pick the addressed lane for byte loads and zero-extend it.
  always_comb begin
    lane_byte = rdata_in[{offset, 3'b000} +: 8];
    rdata_out = byte_op ? {{(DATA_W-8){1'b0}}, lane_byte} : rdata_in;
  end

endmodule

// File: rtl/register_bit.sv
// Single storage bit with write enable, the same cell the pipeline registers use.
module register_bit (
  input  logic clk,
  input  logic reset,
  input  logic write_enable,
  input  logic d,
  output logic q
);

  logic q_reg;

  // Capture d when enabled; cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg <= 1'b0;
    end else if (write_enable) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: turns a load/store into a req/ack memory handshake,
// stalls the pipeline while it is outstanding and reports completion or fault.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MemRead,
  input  logic                   MemWrite,
  input  logic                   ByteOp,
  input  logic [ADDR_W-1:0]      ALUResult,
  input  logic [DATA_W-1:0]      readData2,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DWORD_BYTES-1:0] mem_be,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic                   mem_ack,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   stall,
  output logic [DATA_W-1:0]      memData,
  output logic                   memValid,
  output logic                   fault
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               fault_reg, fault_next;
  logic [DATA_W-1:0]  mem_data_reg, mem_data_next;

  logic               latch_en;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               we_q;
  logic               byte_q;

  logic [DWORD_BYTES-1:0] be_al;
  logic [DATA_W-1:0]      wdata_al;
  logic [DATA_W-1:0]      rdata_al;

  logic any_op;
  logic illegal_op;
  logic busy;

  assign any_op     = MemRead | MemWrite;
  // Both strobes at once, or a doubleword not on an 8-byte boundary, never reaches memory.
  assign illegal_op = (MemRead & MemWrite) |
                      (any_op & ~ByteOp & (ALUResult[2:0] != 3'b000));
  assign busy       = (state_reg == ST_BUSY);

  genvar gi;
  generate
    for (gi = 0; gi < ADDR_W; gi++) begin : g_addr
      register_bit u_addr_bit (
        .clk          (clk),
        .reset        (reset),
        .write_enable (latch_en),
        .d            (ALUResult[gi]),
        .q            (addr_q[gi])
      );
    end
    for (gi = 0; gi < DATA_W; gi++) begin : g_data
      register_bit u_data_bit (
        .clk          (clk),
        .reset        (reset),
        .write_enable (latch_en),
        .d            (readData2[gi]),
        .q            (wdata_q[gi])
      );
    end
  endgenerate

  register_bit u_we_bit (
    .clk          (clk),
    .reset        (reset),
    .write_enable (latch_en),
    .d            (MemWrite),
    .q            (we_q)
  );

  register_bit u_byte_bit (
    .clk          (clk),
    .reset        (reset),
    .write_enable (latch_en),
    .d            (ByteOp),
    .q            (byte_q)
  );

  mem_lane_align u_align (
    .byte_op   (byte_q),
    .offset    (addr_q[2:0]),
    .wdata_in  (wdata_q),
    .rdata_in  (mem_rdata),
    .be        (be_al),
    .wdata_out (wdata_al),
    .rdata_out (rdata_al)
  );

  // State, BUSY-cycle counter, pending fault flag and load result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      fault_reg    <= 1'b0;
      mem_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      fault_reg    <= fault_next;
      mem_data_reg <= mem_data_next;
    end
  end

  // Next-state logic, latch control and stall; counter clears whenever BUSY is left.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = '0;
    fault_next    = fault_reg;
    mem_data_next = mem_data_reg;
    latch_en      = 1'b0;
    stall         = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        fault_next = 1'b0;
        if (illegal_op) begin
          stall      = 1'b1;
          fault_next = 1'b1;
          if (MemRead) mem_data_next = '0;
          state_next = ST_DONE;
        end else if (any_op) begin
          stall      = 1'b1;
          latch_en   = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (mem_ack) begin
          if (!we_q) mem_data_next = rdata_al;
          state_next = ST_DONE;
        end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          fault_next = 1'b1;
          if (!we_q) mem_data_next = '0;
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Memory-side outputs are only driven while a request is outstanding.
  always_comb begin
    mem_req   = busy;
    mem_we    = busy & we_q;
    mem_addr  = busy ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
    mem_be    = busy ? be_al : '0;
    mem_wdata = busy ? wdata_al : '0;
    memData   = mem_data_reg;
    memValid  = (state_reg == ST_DONE);
    fault     = (state_reg == ST_DONE) & fault_reg;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized and directed bench for mem_access_ctrl against a transaction-level model.
module tb_mem_access_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, ByteOp;
  logic [63:0] ALUResult, readData2;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        stall;
  logic [63:0] memData;
  logic        memValid, fault;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .ByteOp(ByteOp),
    .ALUResult(ALUResult), .readData2(readData2), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .stall(stall), .memData(memData), .memValid(memValid),
    .fault(fault)
  );

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  // Expected per-cycle outputs, set by the driver from the transaction schedule.
  logic        exp_stall, exp_req, exp_we, exp_valid, exp_fault;
  logic [63:0] exp_addr, exp_wdata, exp_mem_data;
  logic [7:0]  exp_be;

  int stall_cnt, req_cnt, valid_cnt, fault_cnt;
  logic [63:0] last_addr, last_wdata;
  logic [7:0]  last_be;
  logic        last_we;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: every cycle, all outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("stall",     64'(stall),    64'(exp_stall));
      check("mem_req",   64'(mem_req),  64'(exp_req));
      check("mem_we",    64'(mem_we),   64'(exp_we));
      check("mem_addr",  mem_addr,      exp_addr);
      check("mem_be",    64'(mem_be),   64'(exp_be));
      check("mem_wdata", mem_wdata,     exp_wdata);
      check("memValid",  64'(memValid), 64'(exp_valid));
      check("fault",     64'(fault),    64'(exp_fault));
      check("memData",   memData,       exp_mem_data);
      stall_cnt += int'(stall);
      req_cnt   += int'(mem_req);
      valid_cnt += int'(memValid);
      fault_cnt += int'(fault);
      if (mem_req) begin
        last_addr  = mem_addr;
        last_be    = mem_be;
        last_wdata = mem_wdata;
        last_we    = mem_we;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    stall_cnt = 0; req_cnt = 0; valid_cnt = 0; fault_cnt = 0;
  endtask

  task automatic set_idle_exp();
    exp_stall = 0; exp_req = 0; exp_we = 0; exp_addr = '0;
    exp_be = '0; exp_wdata = '0; exp_valid = 0; exp_fault = 0;
  endtask

  task automatic set_busy_exp(input logic wr, input logic byt, input logic [63:0] addr,
                              input logic [63:0] wd);
    logic [2:0] k;
    k = addr[2:0];
    set_idle_exp();
    exp_stall = 1;
    exp_req   = 1;
    exp_we    = wr;
    exp_addr  = addr & ~64'h7;
    exp_be    = byt ? 8'(1 << k) : 8'hFF;
    exp_wdata = byt ? (64'(wd[7:0]) * 64'h0101010101010101) : wd;
  endtask

  task automatic drive_none();
    MemRead = 0; MemWrite = 0; ByteOp = 1'($urandom_range(0, 1));
    ALUResult = rnd64(); readData2 = rnd64();
  endtask

  // One instruction in MEM: issue cycle, BUSY cycles (ack after ack_delay), DONE cycle.
  task automatic access(input logic rd, input logic wr, input logic byt,
                        input logic [63:0] addr, input logic [63:0] wd,
                        input logic [63:0] rdat, input int ack_delay);
    logic illegal, timeout;
    int nbusy;
    logic [2:0] k;
    k = addr[2:0];
    illegal = (rd && wr) || (!byt && k != 3'd0);
    timeout = 0;
    $display("[TB] txn rd=%0b wr=%0b byte=%0b addr=%h wdata=%h ack_delay=%0d",
             rd, wr, byt, addr, wd, ack_delay);
    cyc();
    MemRead = rd; MemWrite = wr; ByteOp = byt; ALUResult = addr; readData2 = wd;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = rnd64();
    set_idle_exp();
    exp_stall = 1;
    if (!illegal) begin
      timeout = (ack_delay >= TO);
      nbusy   = timeout ? TO : ack_delay + 1;
      for (int c = 1; c <= nbusy; c++) begin
        cyc();
        mem_ack   = (!timeout && c == nbusy);
        mem_rdata = mem_ack ? rdat : rnd64();
        set_busy_exp(wr, byt, addr, wd);
      end
    end
    cyc();
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = rnd64();
    set_idle_exp();
    exp_valid = 1;
    exp_fault = illegal || timeout;
    if (rd) begin
      if (illegal || timeout) exp_mem_data = '0;
      else exp_mem_data = byt ? ((rdat >> (8 * k)) & 64'hFF) : rdat;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      cyc();
      drive_none();
      mem_ack = stray ? 1'b1 : 1'($urandom_range(0, 1));
      mem_rdata = rnd64();
      set_idle_exp();
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1; MemRead = 0; MemWrite = 0; ByteOp = 0; ALUResult = '0; readData2 = '0;
    mem_ack = 0; mem_rdata = '0;
    clr_cnt();
    @(posedge clk); #1;
    set_idle_exp(); exp_mem_data = '0; check_en = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk); #1;
    check("reset_memData", memData, 64'h0);
    check("reset_stall", 64'(stall), 64'h0);

    // Doubleword load, ack on first BUSY cycle.
    clr_cnt();
    access(1, 0, 0, 64'h100, rnd64(), 64'hDEADBEEF_CAFEF00D, 0);
    check("dw_load_memData", memData, 64'hDEADBEEF_CAFEF00D);
    check("dw_load_stall_cycles", 64'(stall_cnt), 64'd2);
    check("dw_load_valid_pulses", 64'(valid_cnt), 64'd1);

    // Byte store to 0x10B.
    clr_cnt();
    access(0, 1, 1, 64'h10B, 64'h12345678_9ABCDE5A, rnd64(), 2);
    check("bs_addr", last_addr, 64'h108);
    check("bs_be", 64'(last_be), 64'h08);
    check("bs_wdata", last_wdata, 64'h5A5A5A5A_5A5A5A5A);
    check("bs_we", 64'(last_we), 64'h1);
    check("bs_memData_kept", memData, 64'hDEADBEEF_CAFEF00D);

    // Byte load from 0x105.
    access(1, 0, 1, 64'h105, rnd64(), 64'h00112233_44556677, 1);
    check("bl_memData", memData, 64'h22);

    // Misaligned doubleword store.
    clr_cnt();
    access(0, 1, 0, 64'h104, rnd64(), rnd64(), 0);
    check("mis_req_cycles", 64'(req_cnt), 64'd0);
    check("mis_stall_cycles", 64'(stall_cnt), 64'd1);
    check("mis_fault_pulses", 64'(fault_cnt), 64'd1);
    check("mis_memData_kept", memData, 64'h22);

    // Ack on the last allowed BUSY cycle still completes.
    clr_cnt();
    access(1, 0, 0, 64'h2A8, rnd64(), 64'h0BADF00D_12345678, TO - 1);
    check("edge_memData", memData, 64'h0BADF00D_12345678);
    check("edge_fault_pulses", 64'(fault_cnt), 64'd0);

    // Timeout on a load, then stray acks in IDLE.
    clr_cnt();
    access(1, 0, 0, 64'h3F0, rnd64(), rnd64(), TO + 3);
    check("to_memData", memData, 64'h0);
    check("to_busy_cycles", 64'(req_cnt), 64'd16);
    check("to_fault_pulses", 64'(fault_cnt), 64'd1);
    clr_cnt();
    idle_cycles(4, 1'b1);
    check("stray_valid_pulses", 64'(valid_cnt), 64'd0);

    // Reset on the 3rd BUSY cycle, then a late ack.
    clr_cnt();
    exp_mem_data = memData === 64'h0 ? 64'h0 : exp_mem_data;
    $display("[TB] txn reset-in-busy load addr=%h", 64'h200);
    cyc();
    MemRead = 1; MemWrite = 0; ByteOp = 0; ALUResult = 64'h200; readData2 = 64'h77;
    mem_ack = 0;
    set_idle_exp(); exp_stall = 1;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      mem_ack = 0;
      set_busy_exp(0, 0, 64'h200, 64'h77);
      if (c == 3) reset = 1;
    end
    cyc();
    reset = 0; drive_none(); mem_ack = 1; mem_rdata = rnd64();
    set_idle_exp(); exp_mem_data = '0;
    @(negedge clk); #1;
    check("rst_busy_req_after", 64'(mem_req), 64'h0);
    check("rst_busy_req_cycles", 64'(req_cnt), 64'd3);
    idle_cycles(1, 1'b1);
    check("rst_busy_valid_pulses", 64'(valid_cnt), 64'd0);
    access(1, 0, 0, 64'h300, rnd64(), 64'hFEEDFACE_00C0FFEE, 1);
    check("rst_next_load", memData, 64'hFEEDFACE_00C0FFEE);

    // Randomized traffic.
    for (int t = 0; t < 80; t++) begin
      int r;
      int dly;
      bit byt;
      logic [63:0] a;
      r   = $urandom_range(0, 9);
      byt = 1'($urandom_range(0, 1));
      a   = rnd64();
      if (!byt && $urandom_range(0, 3) != 0) a[2:0] = 3'd0;
      dly = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 3) : $urandom_range(0, 4);
      case (r)
        0:          access(1, 1, byt, a, rnd64(), rnd64(), dly);
        1, 2, 3, 4: access(1, 0, byt, a, rnd64(), rnd64(), dly);
        5, 6, 7, 8: access(0, 1, byt, a, rnd64(), rnd64(), dly);
        default:    idle_cycles($urandom_range(1, 3), 1'b0);
      endcase
    end

    check_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
